// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, limits, write selectors and the hh:mm record type
// used by the alarm time base and its bench.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX   = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX    = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX    = 6'd59;
  localparam logic [MIN_W-1:0]  SNOOZE_MIN = 6'd5;
  // Seconds after a hit during which a snooze pulse is honoured.
  localparam logic [SEC_W-1:0]  SNOOZE_WIN = 6'd60;

  localparam logic SET_TIME  = 1'b0;
  localparam logic SET_ALARM = 1'b1;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } hhmm_t;

  function automatic logic hhmm_legal(input logic [HOUR_W-1:0] h,
                                      input logic [MIN_W-1:0]  m);
    return (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrap-around counter, modulus MAX+1, advancing by STEP on inc.
//   clk, rst_n   : clock, async active-low reset (value -> 0)
//   clr          : synchronous clear (highest priority)
//   load/load_val: synchronous load (beats inc)
//   inc          : advance by STEP, wrapping past MAX
//   value        : current count
//   next         : value + STEP after wrap (whether or not inc is high)
//   carry        : inc is high and this advance wraps
module mod_counter #(
  parameter int unsigned W    = 6,
  parameter int unsigned MAX  = 59,
  parameter int unsigned STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic [W-1:0] next,
  output logic         carry
);

  localparam logic [W:0] MAX_V  = (W+1)'(MAX);
  localparam logic [W:0] MOD_V  = (W+1)'(MAX + 1);
  localparam logic [W:0] STEP_V = (W+1)'(STEP);

  logic [W:0] sum;
  logic       wrap;

  // One extra bit so value + STEP cannot overflow before the wrap compare.
  assign sum   = {1'b0, value} + STEP_V;
  assign wrap  = sum > MAX_V;
  assign next  = wrap ? W'(sum - MOD_V) : W'(sum);
  assign carry = inc & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= next;
    end
  end

endmodule

// File: rtl/alarm_timebase.sv
// alarm_timebase: 24 h HH:MM:SS time-of-day counter with a programmable alarm.
// Emits a one-cycle match pulse (alarm FSM H input) when a second tick moves
// the time onto alarm_hour:alarm_min:00 with alarm_en high.
//   clk, rst_n          : clock, async active-low reset
//   set_valid/set_ready : write handshake; ready drops in tick cycles
//   set_sel             : SET_TIME (time write) or SET_ALARM (alarm write)
//   set_hour, set_min   : write data; out-of-range data pulses set_err
//   alarm_en            : level, 0 suppresses match
//   hour, min, sec      : current time
//   match               : one-cycle alarm hit pulse
// Optional macro ALARM_SNOOZE_EN adds input snooze: a pulse within 60 s of a
// hit re-arms a hit 5 minutes later; repeated snoozes chain.
module alarm_timebase
  import alarm_pkg::*;
#(
  parameter int CLK_HZ = 10_000,
  parameter int PRE_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic              set_sel,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  output logic              set_err,
  input  logic              alarm_en,
`ifdef ALARM_SNOOZE_EN
  input  logic              snooze,
`endif
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              match
);

  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0]  pre_q;
  logic              ready_q;
  logic              tick;
  logic              accept;
  logic              legal;
  logic              time_wr;
  logic              alarm_wr;
  hhmm_t             alarm_q;

  logic              sec_carry;
  logic              min_carry;
  logic              hour_carry;
  logic [SEC_W-1:0]  sec_nxt;
  logic [MIN_W-1:0]  min_nxt;
  logic [HOUR_W-1:0] hour_nxt;

  hhmm_t             next_hm;
  logic              roll;
  logic              hit_alarm;
  logic              match_d;
  logic              unused;

  assign tick      = (pre_q == PRE_TC);
  assign set_ready = ready_q & ~tick;
  assign accept    = set_valid & set_ready;
  assign legal     = hhmm_legal(set_hour, set_min);
  assign time_wr   = accept & legal & (set_sel == SET_TIME);
  assign alarm_wr  = accept & legal & (set_sel == SET_ALARM);

  mod_counter #(.W(SEC_W), .MAX(SEC_MAX), .STEP(1)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (time_wr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tick),
    .value    (sec),
    .next     (sec_nxt),
    .carry    (sec_carry)
  );

  mod_counter #(.W(MIN_W), .MAX(MIN_MAX), .STEP(1)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (time_wr),
    .load_val (set_min),
    .inc      (sec_carry),
    .value    (min),
    .next     (min_nxt),
    .carry    (min_carry)
  );

  mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX), .STEP(1)) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (time_wr),
    .load_val (set_hour),
    .inc      (min_carry),
    .value    (hour),
    .next     (hour_nxt),
    .carry    (hour_carry)
  );

  // Hits are detected on the hh:mm the cascade is about to produce, so only a
  // tick rolling sec 59 -> 0 can cause one; writes never do.
  assign roll         = tick & (sec == SEC_MAX);
  assign next_hm.min  = min_nxt;
  assign next_hm.hour = (min == MIN_MAX) ? hour_nxt : hour;
  assign hit_alarm    = roll & (next_hm == alarm_q);

`ifdef ALARM_SNOOZE_EN
  logic              pend_q;
  logic [SEC_W-1:0]  win_q;
  logic              prim_hit;
  logic              snz_take;
  logic              hit_snz;
  logic [MIN_W-1:0]  tgt_min;
  logic [HOUR_W-1:0] tgt_hour;
  logic [MIN_W-1:0]  tgt_min_nxt;
  logic [HOUR_W-1:0] tgt_hour_nxt;
  logic              tgt_min_carry;
  logic              tgt_hour_carry;

  assign prim_hit = hit_alarm & alarm_en;
  assign snz_take = snooze & alarm_en & (win_q != '0);
  assign hit_snz  = roll & pend_q & (next_hm == {tgt_hour, tgt_min});
  assign match_d  = alarm_en & (hit_alarm | hit_snz);

  // Snooze target: restarts from the alarm time on every primary hit, then
  // advances 5 minutes (mod 24 h) per accepted snooze so snoozes chain.
  mod_counter #(.W(MIN_W), .MAX(MIN_MAX), .STEP(SNOOZE_MIN)) u_tgt_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (prim_hit),
    .load_val (alarm_q.min),
    .inc      (snz_take),
    .value    (tgt_min),
    .next     (tgt_min_nxt),
    .carry    (tgt_min_carry)
  );

  mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX), .STEP(1)) u_tgt_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (prim_hit),
    .load_val (alarm_q.hour),
    .inc      (tgt_min_carry),
    .value    (tgt_hour),
    .next     (tgt_hour_nxt),
    .carry    (tgt_hour_carry)
  );

  // win_q counts down the seconds left in which a snooze is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      win_q  <= '0;
    end else if (alarm_wr || !alarm_en) begin
      pend_q <= 1'b0;
      win_q  <= '0;
    end else begin
      if (match_d) begin
        win_q <= SNOOZE_WIN;
      end else if (snz_take) begin
        win_q <= '0;
      end else if (tick && (win_q != '0)) begin
        win_q <= win_q - SEC_W'(1);
      end

      if (snz_take) begin
        pend_q <= 1'b1;
      end else if (hit_snz) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign unused = &{1'b0, sec_nxt, hour_carry, tgt_min_nxt, tgt_hour_nxt,
                    tgt_hour_carry};
`else
  assign match_d = alarm_en & hit_alarm;
  assign unused  = &{1'b0, sec_nxt, hour_carry, SNOOZE_MIN, SNOOZE_WIN};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
      set_err <= 1'b0;
      alarm_q <= '0;
      match   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      set_err <= accept & ~legal;
      match   <= match_d;
      if (tick || time_wr) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      if (alarm_wr) begin
        alarm_q.hour <= set_hour;
        alarm_q.min  <= set_min;
      end
    end
  end

endmodule
